// File: rtl/neopixel_multi_pkg.sv
// Shared register map, FSM states and bit-timing helper for the multi-strand NeoPixel driver.
package neopixel_pkg;

    localparam logic [31:0] ADDR_CTRL   = 32'h0000_0000;
    localparam logic [31:0] ADDR_STATUS = 32'h0000_0004;
    localparam logic [31:0] ADDR_LEN    = 32'h0000_0008;
    localparam logic [31:0] ADDR_PIX    = 32'h0000_1000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_GAP
    } state_t;

    // Cycles for a duration in ns at clk_mhz, truncated.
    function automatic int calc_cycles(input int clk_mhz, input int ns);
        return (clk_mhz * ns) / 1000;
    endfunction

endpackage

// File: rtl/neopixel_multi_shifter.sv
// One strand: 32-bit pixel shift register and registered line driver keyed off the shared bit timer.
module neopixel_shifter #(
    parameter int C_CW   = 14,
    parameter int C_THR0 = 106,
    parameter int C_THR1 = 56
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            i_load,
    input  logic [31:0]     i_load_data,
    input  logic            i_shift,
    input  logic            i_enable,
    input  logic            i_active,
    input  logic [C_CW-1:0] i_cyc_cnt,
    output logic            o_drive
);

    localparam logic [C_CW-1:0] L_THR0 = C_CW'(C_THR0);
    localparam logic [C_CW-1:0] L_THR1 = C_CW'(C_THR1);

    logic [31:0]     r_shreg;
    logic [C_CW-1:0] w_thr;

    // The bit timer counts down from TBIT-1, so the high phase is the top of the count.
    assign w_thr = r_shreg[31] ? L_THR1 : L_THR0;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_shreg <= '0;
            o_drive <= 1'b0;
        end else begin
            if (i_load)
                r_shreg <= i_load_data;
            else if (i_shift)
                r_shreg <= {r_shreg[30:0], 1'b0};
            o_drive <= i_active && i_enable && (i_cyc_cnt >= w_thr);
        end
    end

endmodule

// File: rtl/neopixel_multi.sv
// Multi-channel WS2812/SK6812 driver: register file, per-channel pixel banks, frame FSM and shared timers.
//   state    | meaning
//   ST_IDLE  | waiting for start; pixel 0 is fetched on the start cycle
//   ST_LOAD  | fetched pixel 0 moves into every shifter
//   ST_SHIFT | bit timer running; next pixel fetched one cycle before its boundary
//   ST_GAP   | outputs low for the reset gap, then done
module neopixel_multi
    import neopixel_pkg::*;
#(
    parameter int C_CHANNELS = 4,
    parameter int C_PIXELS   = 64,
    parameter int C_CLK_MHZ  = 125
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  write_readf,
    input  logic [31:0]           address,
    input  logic [31:0]           write_data,
    output logic [31:0]           read_data,
    output logic [C_CHANNELS-1:0] neopixel_drive
);

    localparam int T0H  = calc_cycles(C_CLK_MHZ, 400);
    localparam int T1H  = calc_cycles(C_CLK_MHZ, 800);
    localparam int TBIT = calc_cycles(C_CLK_MHZ, 1250);
    localparam int TRST = calc_cycles(C_CLK_MHZ, 80000);
    localparam int CW   = $clog2(TRST + 1);
    localparam int PW   = $clog2(C_PIXELS);
    localparam int CHW  = (C_CHANNELS > 1) ? $clog2(C_CHANNELS) : 1;
    localparam int NW   = C_CHANNELS * C_PIXELS;

    localparam logic [29:0] L_W_CTRL   = ADDR_CTRL[31:2];
    localparam logic [29:0] L_W_STATUS = ADDR_STATUS[31:2];
    localparam logic [29:0] L_W_LEN    = ADDR_LEN[31:2];
    localparam logic [29:0] L_W_PIX    = ADDR_PIX[31:2];

    logic [31:0] r_mem [C_CHANNELS][C_PIXELS];

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [4:0]      r_bit;
    logic [10:0]     r_px;
    logic [10:0]     r_len;
    logic            r_rgbw;
    logic [7:0]      r_mask;
    logic            r_busy;
    logic            r_done;
    logic            r_ctrl_rgbw;
    logic [7:0]      r_ctrl_mask;
    logic [10:0]     r_len_reg;

    logic [29:0]     w_word;
    logic [29:0]     w_pix_off;
    logic            w_pix_hit;
    logic [PW-1:0]   w_px;
    logic [CHW-1:0]  w_ch;
    logic            w_start;
    logic [10:0]     w_len_clamp;
    logic            w_last_px;
    logic            w_bit_end;
    logic            w_fetch;
    logic [PW-1:0]   w_fetch_px;
    logic            w_load;
    logic            w_shift;
    logic [31:0]     w_rd;
    logic            w_unused;

    assign w_unused    = ^address[1:0];
    assign w_word      = address[31:2];
    assign w_pix_off   = w_word - L_W_PIX;
    assign w_pix_hit   = (w_word >= L_W_PIX) && (w_pix_off < 30'(NW));
    assign w_px        = w_pix_off[PW-1:0];
    assign w_ch        = w_pix_off[PW +: CHW];
    assign w_start     = write_readf && (w_word == L_W_CTRL) && write_data[0];
    assign w_len_clamp = (r_len_reg > 11'(C_PIXELS)) ? 11'(C_PIXELS) : r_len_reg;
    assign w_last_px   = (r_px == r_len - 11'd1);
    assign w_bit_end   = (r_state == ST_SHIFT) && (r_bit == 5'd0);

    assign w_fetch    = ((r_state == ST_IDLE) && w_start && (w_len_clamp != 11'd0)) ||
                        (w_bit_end && (r_cnt == CW'(1)) && !w_last_px);
    assign w_fetch_px = (r_state == ST_IDLE) ? '0 : (r_px[PW-1:0] + 1'b1);
    assign w_load     = (r_state == ST_LOAD) || (w_bit_end && (r_cnt == '0) && !w_last_px);
    assign w_shift    = (r_state == ST_SHIFT) && (r_cnt == '0) && (r_bit != 5'd0);

    always_comb begin
        w_rd = '0;
        if (w_word == L_W_CTRL)
            w_rd = {16'd0, r_ctrl_mask, 6'd0, r_ctrl_rgbw, 1'b0};
        else if (w_word == L_W_STATUS)
            w_rd = {30'd0, r_done, r_busy};
        else if (w_word == L_W_LEN)
            w_rd = {21'd0, r_len_reg};
        else if (w_pix_hit)
            w_rd = r_mem[w_ch][w_px];
    end

    always_ff @(posedge clock) begin
        if (write_readf && w_pix_hit)
            r_mem[w_ch][w_px] <= write_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bit       <= '0;
            r_px        <= '0;
            r_len       <= '0;
            r_rgbw      <= 1'b0;
            r_mask      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ctrl_rgbw <= 1'b0;
            r_ctrl_mask <= '0;
            r_len_reg   <= '0;
            read_data   <= '0;
        end else begin
            if (write_readf) begin
                if (w_word == L_W_CTRL) begin
                    r_ctrl_rgbw <= write_data[1];
                    r_ctrl_mask <= write_data[15:8];
                end
                if ((w_word == L_W_STATUS) && write_data[1])
                    r_done <= 1'b0;
                if (w_word == L_W_LEN)
                    r_len_reg <= write_data[10:0];
            end else begin
                read_data <= w_rd;
            end

            // Done-set sits after the clear above so it wins a same-cycle collision.
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_rgbw <= write_data[1];
                        r_mask <= write_data[15:8];
                        r_len  <= w_len_clamp;
                        r_px   <= '0;
                        r_busy <= 1'b1;
                        if (w_len_clamp == 11'd0) begin
                            r_state <= ST_GAP;
                            r_cnt   <= CW'(TRST);
                        end else begin
                            r_state <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    r_state <= ST_SHIFT;
                    r_cnt   <= CW'(TBIT - 1);
                    r_bit   <= r_rgbw ? 5'd31 : 5'd23;
                end
                ST_SHIFT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (r_bit != 5'd0) begin
                        r_bit <= r_bit - 5'd1;
                        r_cnt <= CW'(TBIT - 1);
                    end else if (w_last_px) begin
                        r_state <= ST_GAP;
                        r_cnt   <= CW'(TRST);
                    end else begin
                        r_px  <= r_px + 11'd1;
                        r_bit <= r_rgbw ? 5'd31 : 5'd23;
                        r_cnt <= CW'(TBIT - 1);
                    end
                end
                ST_GAP: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < C_CHANNELS; g++) begin : g_ch
        logic [31:0] r_next;

        always_ff @(posedge clock) begin
            if (w_fetch)
                r_next <= r_mem[g][w_fetch_px];
        end

        // Pixel word is {W,G,R,B}; wire order is G,R,B,W.
        neopixel_shifter #(
            .C_CW   (CW),
            .C_THR0 (TBIT - T0H),
            .C_THR1 (TBIT - T1H)
        ) u_shifter (
            .clock       (clock),
            .reset       (reset),
            .i_load      (w_load),
            .i_load_data ({r_next[23:0], r_next[31:24]}),
            .i_shift     (w_shift),
            .i_enable    (r_mask[g]),
            .i_active    (r_state == ST_SHIFT),
            .i_cyc_cnt   (r_cnt),
            .o_drive     (neopixel_drive[g])
        );
    end

endmodule

// File: tb/tb_neopixel_multi.sv
// Directed bench for neopixel_multi with 2 channels, 8 pixels per bank, 125 MHz timing.
module tb_neopixel_multi;

    localparam int TBIT = 156;
    localparam int TRST = 10000;
    localparam int HI1  = 100;
    localparam int HI0  = 50;

    logic        clock = 1'b0;
    logic        reset;
    logic        write_readf;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic [1:0]  neopixel_drive;

    int checks   = 0;
    int failures = 0;

    logic        exp_bits [2][256];
    logic [31:0] tb_mem   [2][8];

    neopixel_multi #(
        .C_CHANNELS (2),
        .C_PIXELS   (8),
        .C_CLK_MHZ  (125)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .write_readf    (write_readf),
        .address        (address),
        .write_data     (write_data),
        .read_data      (read_data),
        .neopixel_drive (neopixel_drive)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the write lands on the next posedge, then the bus returns to reading STATUS.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        write_readf = 1'b1;
        address     = a;
        write_data  = d;
        @(negedge clock);
        write_readf = 1'b0;
        address     = 32'h4;
        write_data  = 32'h0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        write_readf = 1'b0;
        address     = a;
        @(negedge clock);
        d       = read_data;
        address = 32'h4;
    endtask

    task automatic put_pixel(input int ch, input int px, input logic [31:0] word, input bit rgbw);
        logic [31:0] seq;
        int nb;
        seq = {word[23:16], word[15:8], word[7:0], word[31:24]};
        nb  = rgbw ? 32 : 24;
        for (int j = 0; j < nb; j++)
            exp_bits[ch][px*nb + j] = seq[31-j];
        tb_mem[ch][px] = word;
        bus_write(32'h1000 + 32'(4 * (ch*8 + px)), word);
    endtask

    // Start at edge N: busy visible from the read at N+1, first high at N+2 (returns on that sample).
    task automatic start_frame(input logic [7:0] mask, input bit rgbw, input string tag);
        bus_write(32'h0, {16'd0, mask, 6'd0, rgbw, 1'b1});
        @(negedge clock);
        chk({tag, "_drive_n1"}, 32'(neopixel_drive), 32'h0);
        chk({tag, "_busy_n1"}, read_data & 32'h1, 32'h1);
        @(negedge clock);
    endtask

    task automatic measure(input int nbits, input logic [1:0] en, input int restart_bit, input string tag);
        int   w [2];
        logic first [2];
        for (int i = 0; i < nbits; i++) begin
            w[0] = 0;
            w[1] = 0;
            for (int k = 0; k < TBIT; k++) begin
                for (int c = 0; c < 2; c++) begin
                    if (neopixel_drive[c]) w[c]++;
                    if (k == 0) first[c] = neopixel_drive[c];
                end
                if (i == restart_bit && k == 0) begin
                    write_readf = 1'b1; address = 32'h0; write_data = 32'h0000_0103;
                end else if (i == restart_bit && k == 1) begin
                    address = 32'h8; write_data = 32'h7;
                end else if (i == restart_bit && k == 2) begin
                    write_readf = 1'b0; address = 32'h4; write_data = 32'h0;
                end
                @(negedge clock);
            end
            for (int c = 0; c < 2; c++) begin
                chk($sformatf("%s_width_ch%0d_bit%0d", tag, c, i), 32'(w[c]),
                    en[c] ? (exp_bits[c][i] ? 32'(HI1) : 32'(HI0)) : 32'h0);
                chk($sformatf("%s_lead_ch%0d_bit%0d", tag, c, i), 32'(first[c]), 32'(en[c]));
            end
        end
    endtask

    // Entered on the first sample after the last bit; done is registered TRST+1 cycles later and read one after that.
    task automatic wait_done(input string tag);
        int c = 0;
        int highs = 0;
        while (read_data[1] !== 1'b1 && c < 2*TRST) begin
            if (neopixel_drive != 2'b00) highs++;
            c++;
            @(negedge clock);
        end
        chk({tag, "_gap_cycles"}, 32'(c), 32'(TRST + 1));
        chk({tag, "_gap_highs"}, 32'(highs), 32'h0);
        chk({tag, "_status_end"}, 32'(read_data[1:0]), 32'h2);
    endtask

    task automatic quiet(input int n, input string tag);
        int highs = 0;
        repeat (n) begin
            if (neopixel_drive != 2'b00) highs++;
            @(negedge clock);
        end
        chk({tag, "_quiet_highs"}, 32'(highs), 32'h0);
    endtask

    initial begin
        logic [31:0] d;

        reset = 1'b1; write_readf = 1'b0; address = 32'h4; write_data = 32'h0;
        repeat (3) @(negedge clock);
        chk("rst_read_data", read_data, 32'h0);
        chk("rst_drive", 32'(neopixel_drive), 32'h0);
        reset = 1'b0;
        bus_read(32'h4, d); chk("rst_status", d, 32'h0);
        bus_read(32'h0, d); chk("rst_ctrl", d, 32'h0);
        bus_read(32'h8, d); chk("rst_len", d, 32'h0);

        // Register readback and read latency
        put_pixel(1, 7, 32'hDEAD_BEEF, 1'b1);
        bus_write(32'h8, 32'hFFFF_FFFF);
        bus_read(32'h8, d); chk("len_mask", d, 32'h7FF);
        bus_write(32'h0, 32'h0000_A502);
        bus_read(32'h0, d); chk("ctrl_rb", d, 32'h0000_A502);
        bus_read(32'h103F, d); chk("pix_rb_low_bits_ignored", d, 32'hDEAD_BEEF);
        bus_read(32'hC, d); chk("unmapped_c", d, 32'h0);
        bus_read(32'h1040, d); chk("unmapped_past_pix", d, 32'h0);
        write_readf = 1'b0; address = 32'h103C;
        @(negedge clock); chk("b2b_first", read_data, 32'hDEAD_BEEF);
        address = 32'h8;
        @(negedge clock); chk("b2b_second", read_data, 32'h7FF);

        // Scenario 1: RGB single pixel on ch0 only
        bus_write(32'h8, 32'h1);
        put_pixel(0, 0, 32'h0080_01FF, 1'b0);
        put_pixel(1, 0, 32'hFFFF_FFFF, 1'b0);
        start_frame(8'h01, 1'b0, "s1");
        measure(24, 2'b01, -1, "s1");
        wait_done("s1");
        bus_write(32'h4, 32'h2);
        bus_read(32'h4, d); chk("s1_done_cleared", d, 32'h0);

        // Scenario 2: two channels, 3 pixels, start + LEN write while busy
        bus_write(32'h8, 32'h3);
        put_pixel(0, 0, 32'h0012_3456, 1'b0);
        put_pixel(0, 1, 32'h00F0_0FA5, 1'b0);
        put_pixel(0, 2, 32'h00FF_0081, 1'b0);
        put_pixel(1, 0, 32'h00C3_3C69, 1'b0);
        put_pixel(1, 1, 32'h0001_8000, 1'b0);
        put_pixel(1, 2, 32'h007E_7E7E, 1'b0);
        start_frame(8'h03, 1'b0, "s2");
        measure(72, 2'b11, 10, "s2");
        wait_done("s2");
        bus_read(32'h8, d); chk("s2_len_after", d, 32'h7);
        bus_read(32'h0, d); chk("s2_ctrl_after", d, 32'h0000_0102);
        bus_write(32'h4, 32'h2);

        // Scenario 3: RGBW, W byte 0xAA; abort with reset once the 32 bits are checked
        bus_write(32'h8, 32'h1);
        put_pixel(0, 0, 32'hAA00_0000, 1'b1);
        start_frame(8'h01, 1'b1, "s3");
        measure(32, 2'b01, -1, "s3");
        quiet(50, "s3");
        chk("s3_busy_in_gap", read_data & 32'h3, 32'h1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("s3_reset_drive", 32'(neopixel_drive), 32'h0);

        // LEN=0: no pulses, and a W1C landing on the done-set edge loses
        bus_write(32'h8, 32'h0);
        start_frame(8'h03, 1'b0, "len0");
        quiet(TRST - 2, "len0");
        chk("len0_busy_before_done", read_data & 32'h3, 32'h1);
        bus_write(32'h4, 32'h2);
        bus_read(32'h4, d); chk("len0_set_wins", d, 32'h2);
        bus_write(32'h4, 32'h2);
        bus_read(32'h4, d); chk("len0_w1c", d, 32'h0);

        // LEN=20 clamps to 8 pixels
        bus_write(32'h8, 32'd20);
        for (int p = 0; p < 8; p++)
            put_pixel(0, p, 32'h0055_AA00 ^ (32'(p) * 32'h0011_1111), 1'b0);
        start_frame(8'h01, 1'b0, "clamp");
        measure(192, 2'b01, -1, "clamp");
        quiet(300, "clamp");
        chk("clamp_busy_in_gap", read_data & 32'h3, 32'h1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;

        // Reset at cycle 3000 of a frame
        bus_write(32'h8, 32'h2);
        start_frame(8'h03, 1'b0, "s5");
        repeat (2997) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("s5_drive", 32'(neopixel_drive), 32'h0);
        chk("s5_read_data", read_data, 32'h0);
        bus_read(32'h4, d); chk("s5_status", d, 32'h0);
        bus_read(32'h8, d); chk("s5_len", d, 32'h0);
        bus_read(32'h0, d); chk("s5_ctrl", d, 32'h0);
        bus_read(32'h1000 + 32'(4*5), d); chk("s5_pix_ch0_5", d, tb_mem[0][5]);
        bus_read(32'h1000 + 32'(4*(8+2)), d); chk("s5_pix_ch1_2", d, tb_mem[1][2]);
        quiet(200, "s5");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/neopixel_multi.md
# neopixel_multi

Multi-channel successor to the single-strand `neopixel` block. It drives `C_CHANNELS` WS2812/SK6812 strands in parallel from per-channel pixel memories, in either GRB (24-bit) or GRBW (32-bit) mode. Bit timing is derived from `C_CLK_MHZ`. The block sits on the same word-addressed control bus as `neopixel` (`write_readf`/`address`/`write_data`/`read_data`). That bus is driven by `neopixel_driver` or by the PS bridge, and runs in the same clock domain as the block.

## Interface
- `C_CHANNELS`, 4: number of strands, 1..8.
- `C_PIXELS`, 64: pixel-memory depth per channel, power of two, max 1024.
- `C_CLK_MHZ`, 125: frequency of `clock`, used for timing constants.
- `clock` in 1: single clock for bus and output logic.
- `reset` in 1: synchronous, active-high.
- `write_readf` in 1: 1 = write this cycle, 0 = read.
- `address` in 32: byte address; `[1:0]` ignored.
- `write_data` in 32: write data.
- `read_data` out 32: registered read data. Resets to 0.
- `neopixel_drive` out `C_CHANNELS`: strand data outputs. Reset to 0.

## Operation
- Address map (word offsets):
  - `0x000` CTRL
    - `[0]` start: write-1 pulse, reads 0.
    - `[1]` rgbw.
    - `[15:8]` channel enable mask.
  - `0x004` STATUS
    - `[0]` busy: read-only.
    - `[1]` done: sticky, write-1-to-clear.
  - `0x008` LEN: pixels per frame, `[10:0]`.
  - `0x1000 + 4*(ch*C_PIXELS + px)`: pixel word `{W[31:24], G[23:16], R[15:8], B[7:0]}`.
  - Unmapped reads return 0.
- Reset values:
  - CTRL = 0, LEN = 0, busy = 0, done = 0.
  - All `neopixel_drive` = 0.
  - Pixel memory is not cleared.
- Transmit order per pixel: G, R, B, then W when rgbw=1. Each byte is sent MSB first.
- Timing constants, computed with integer truncation:
  - T0H = C_CLK_MHZ*400/1000.
  - T1H = C_CLK_MHZ*800/1000.
  - TBIT = C_CLK_MHZ*1250/1000.
  - TRST = C_CLK_MHZ*80.
  - At 125 MHz these are 50, 100, 156 and 10000 cycles.
- FSM states: IDLE → LOAD → SHIFT → GAP → IDLE.
  - IDLE: on start=1, latch rgbw, mask, and len = min(LEN, C_PIXELS). Set busy. If len = 0, go to GAP; otherwise go to LOAD.
  - LOAD: read pixel 0 of every bank into the per-channel shift registers. Takes 1 cycle.
  - SHIFT: a shared bit counter and cycle counter. The output is high for T0H or T1H, then low until TBIT.
    - The next pixel is read during the last bit's low phase and loaded at its TBIT boundary, so no bit period is stretched.
    - After the last bit of pixel len-1, go to GAP.
  - GAP: all outputs low for TRST cycles. Then clear busy, set done, return to IDLE.
- Disabled channels hold 0 for the whole frame. All enabled channels toggle on identical cycles.
- start while busy is ignored. CTRL, LEN and mask writes made while busy take effect at the next start.
- Pixel-memory writes while busy are allowed. A word affects the frame only if it is written before that pixel's fetch cycle.
- Same-cycle STATUS write-1-to-clear and done-set: the set wins.
- reset mid-frame: on the next cycle the FSM is IDLE, outputs are 0 and registers are at reset values.

## Timing
- `read_data` is valid 1 cycle after the read cycle. Reads have no side effects.
- A write to the CTRL start bit at edge N gives:
  - STATUS busy reads 1 from a read issued at N+1.
  - First high on enabled `neopixel_drive` at N+2.
- Frame duration from first high to done set: len*B*TBIT + TRST cycles, where B = 24 or 32.

## Structure
- Package `neopixel_pkg` holds:
  - Register offset localparams.
  - `function` for timing-constant computation.
  - `typedef enum` of FSM states.
- Sub-module `neopixel_shifter`: one per channel, instantiated by `generate`. It contains the 32-bit shift register, load/shift/enable inputs, and a registered output that produces high time from the shared counter.
- The top level owns the register file, the memory banks (one array per channel for a parallel read), the FSM and the counters.

## Test plan
All scenarios use C_CHANNELS=2, C_PIXELS=8, C_CLK_MHZ=125.
1. RGB, single pixel: ch0 px0=0x00_80_01_FF, LEN=1, mask=0x01, start.
   - ch0 high widths: 100, 50×7, 50×7, 100, 100×8.
   - Each bit period is 156 cycles.
   - Then 10000 low cycles, done=1.
   - ch1 held 0 throughout.
2. Two channels, LEN=3, mask=0x03, differing data.
   - Both rising edges occur on identical cycles.
   - High widths match each bank's bits.
   - Total 3*24*156+10000 cycles.
3. RGBW mode, px0=0xAA000000.
   - 32 bits; the last 8 alternate 100/50 high.
4. Edge cases:
   - LEN=0: no pulses; done set after 10000 cycles.
   - LEN=20: clamped, sends 8 pixels.
   - start during busy: frame length unchanged.
5. Assert reset at cycle 3000 of a frame.
   - Next cycle: outputs 0, busy=0, LEN reads 0.
   - Pixel memory reads back the written values.
6. Register readback.
   - Write/read pixel memory and LEN; each read returns data 1 cycle later.
   - done write-1-to-clear works; a same-cycle set wins.
